// File: rtl/lsu_pkg.sv
// Shared definitions for the banked load/store unit: op codes, lane count, response states.
// Latency: n/a (constants and pure helpers only).
// Backpressure: n/a.
package lsu_pkg;

  localparam int LANES = 4;

  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LBU = 4'h1;
  localparam logic [3:0] OP_LH  = 4'h2;
  localparam logic [3:0] OP_LHU = 4'h3;
  localparam logic [3:0] OP_LW  = 4'h4;
  localparam logic [3:0] OP_LWL = 4'h5;
  localparam logic [3:0] OP_LWR = 4'h6;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_SWL = 4'hB;
  localparam logic [3:0] OP_SWR = 4'hC;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_t;

  // Stores occupy the upper half of the op-code space.
  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for MIPS32 loads/stores: byte enables, write word, extended/merged load word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; LWL/LWR/SWL/SWR only built when LSU_UNALIGNED_EN is defined, else illegal.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [3:0]       op,
  input  logic [1:0]       off,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rt,
  input  logic [31:0]      word,
  output logic [LANES-1:0] be,
  output logic [31:0]      wword,
  output logic [31:0]      rdata,
  output logic             misalign,
  output logic             illegal
);

  // Big-endian: byte offset k lives in lane 3-k, so ~off selects the lane.
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  assign lbyte = word[{~off, 3'b000} +: 8];
  assign lhalf = off[1] ? word[15:0] : word[31:16];

`ifndef LSU_UNALIGNED_EN
  // The merge operand only matters for LWL/LWR, which are absent in this build.
  logic unused_rt;
  assign unused_rt = ^rt;
`endif

  // Decode the op, steer lanes, then squash writes and data on any error.
  always_comb begin
    be       = '0;
    wword    = '0;
    rdata    = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_LB:  rdata = {{24{lbyte[7]}}, lbyte};
      OP_LBU: rdata = {24'h0, lbyte};
      OP_LH: begin
        misalign = off[0];
        rdata    = {{16{lhalf[15]}}, lhalf};
      end
      OP_LHU: begin
        misalign = off[0];
        rdata    = {16'h0, lhalf};
      end
      OP_LW: begin
        misalign = (off != 2'd0);
        rdata    = word;
      end
      OP_SB: begin
        be    = 4'b0001 << ~off;
        wword = {4{wdata[7:0]}};
      end
      OP_SH: begin
        misalign = off[0];
        be       = off[1] ? 4'b0011 : 4'b1100;
        wword    = {2{wdata[15:0]}};
      end
      OP_SW: begin
        misalign = (off != 2'd0);
        be       = 4'b1111;
        wword    = wdata;
      end
`ifdef LSU_UNALIGNED_EN
      OP_LWL: rdata = (word << {off, 3'b000}) | (rt & ~(32'hFFFF_FFFF << {off, 3'b000}));
      OP_LWR: rdata = (rt & ~(32'hFFFF_FFFF >> {~off, 3'b000})) | (word >> {~off, 3'b000});
      OP_SWL: begin
        be    = 4'b1111 >> off;
        wword = wdata >> {off, 3'b000};
      end
      OP_SWR: begin
        be    = 4'b1111 << ~off;
        wword = wdata << {~off, 3'b000};
      end
`else
      OP_LWL, OP_LWR, OP_SWL, OP_SWR: illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
    if (misalign || illegal || !is_store(op)) be = '0;
    if (misalign || illegal) rdata = '0;
  end

endmodule

// File: rtl/lsu_banked_dram.sv
// Byte-banked data RAM with MIPS32 lane steering; optional LWL/LWR/SWL/SWR via LSU_UNALIGNED_EN.
// Latency: one cycle from accept to response; stores write and loads read at the accept edge.
// Backpressure: req_ready = !resp_valid || resp_ready; stalled responses hold in a register.
module lsu_banked_dram
  import lsu_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_W;

  // Each word is four packed byte lanes; lane 3 is bits 31:24 (byte offset 0).
  logic [LANES-1:0][7:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       raw_word;
  logic [LANES-1:0]  be;
  logic [31:0]       wword;
  logic [31:0]       ld_data;
  logic              misalign;
  logic              illegal;
  resp_state_t       state;

  // Address bits above the RAM depth are ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_ready  = (state == RESP_EMPTY) || resp_ready;
  assign resp_valid = (state == RESP_FULL);
  assign accept     = req_valid && req_ready;
  assign widx       = req_addr[ADDR_W+1:2];
  assign raw_word   = mem[widx];

  lsu_lane_align u_align (
    .op       (req_op),
    .off      (req_addr[1:0]),
    .wdata    (req_wdata),
    .rt       (req_rt),
    .word     (raw_word),
    .be       (be),
    .wword    (wword),
    .rdata    (ld_data),
    .misalign (misalign),
    .illegal  (illegal)
  );

  // Byte-enabled bank writes at the accept edge; contents survive reset, nothing writes while in reset.
  always_ff @(posedge clk) begin
    if (accept && rst) begin
      for (int l = 0; l < LANES; l++) begin
        if (be[l]) mem[widx][l] <= wword[8*l +: 8];
      end
    end
  end

  // Response register: capture steered data on accept, drain on resp_ready, hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RESP_EMPTY;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        RESP_EMPTY: begin
          if (accept) begin
            state     <= RESP_FULL;
            resp_data <= ld_data;
            resp_err  <= misalign || illegal;
          end
        end
        RESP_FULL: begin
          if (accept) begin
            resp_data <= ld_data;
            resp_err  <= misalign || illegal;
          end else if (resp_ready) begin
            state <= RESP_EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_banked_dram.sv
// Directed bench for lsu_banked_dram: vector table plus back-pressure and reset sequences.
// Latency: expects each response one cycle after its accept.
// Backpressure: exercises a 3-cycle resp_ready stall on a 4-load stream.
module tb_lsu_banked_dram;
  import lsu_pkg::*;

`ifdef LSU_UNALIGNED_EN
  localparam bit UA = 1'b1;
`else
  localparam bit UA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_rt = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  lsu_banked_dram dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rt     (req_rt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rt, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.rt = rt; v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // Single accepted op with resp_ready high; leaves req_valid low afterwards.
  task automatic single_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt = '0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  logic [3:0]  bp_op   [4];
  logic [31:0] bp_addr [4];
  logic [31:0] bp_exp  [4];

  initial begin
    // Byte store/load
    add(OP_SB,  32'h3, 32'h0000_00FF, 32'h0, 32'h0, 1'b0);
    add(OP_SB,  32'h2, 32'h0000_00EE, 32'h0, 32'h0, 1'b0);
    add(OP_LB,  32'h3, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    add(OP_LBU, 32'h2, 32'h0, 32'h0, 32'h0000_00EE, 1'b0);
    // Halfword
    add(OP_SH,  32'h0, 32'h0000_AABB, 32'h0, 32'h0, 1'b0);
    add(OP_LH,  32'h0, 32'h0, 32'h0, 32'hFFFF_AABB, 1'b0);
    add(OP_LHU, 32'h0, 32'h0, 32'h0, 32'h0000_AABB, 1'b0);
    add(OP_LH,  32'h1, 32'h0, 32'h0, 32'h0, 1'b1);
    add(OP_SH,  32'h1, 32'h0000_1234, 32'h0, 32'h0, 1'b1);
    add(OP_LW,  32'h0, 32'h0, 32'h0, 32'hAABB_EEFF, 1'b0);
    // Word and merge
    add(OP_SW,  32'h8, 32'h4455_6677, 32'h0, 32'h0, 1'b0);
    add(OP_LW,  32'h8, 32'h0, 32'h0, 32'h4455_6677, 1'b0);
    add(OP_LWR, 32'h8, 32'h0, 32'hBB88_9977, UA ? 32'hBB88_9944 : 32'h0, !UA);
    add(OP_LWL, 32'h9, 32'h0, 32'hBB88_9977, UA ? 32'h5566_7777 : 32'h0, !UA);
    // SWL / SWR
    add(OP_SW,  32'hC, 32'h0, 32'h0, 32'h0, 1'b0);
    add(OP_SWL, 32'hE, 32'h1122_3344, 32'h0, 32'h0, !UA);
    add(OP_LW,  32'hC, 32'h0, 32'h0, UA ? 32'h0000_1122 : 32'h0, 1'b0);
    add(OP_SWR, 32'hD, 32'h1122_3344, 32'h0, 32'h0, !UA);
    add(OP_LW,  32'hC, 32'h0, 32'h0, UA ? 32'h3344_1122 : 32'h0, 1'b0);
    // Misaligned word, address wrap, illegal op, misaligned store
    add(OP_LW,  32'h1, 32'h0, 32'h0, 32'h0, 1'b1);
    add(OP_LBU, 32'h1002, 32'h0, 32'h0, 32'h0000_00EE, 1'b0);
    add(4'h7,   32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    add(OP_SW,  32'h6, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1);
    add(OP_LW,  32'h4, 32'h0, 32'h0, 32'h0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_resp_valid", resp_valid, 0);
    check("reset_resp_data",  resp_data,  0);
    check("reset_resp_err",   resp_err,   0);
    check("reset_req_ready",  req_ready,  1);
    @(negedge clk) rst = 1'b1;

    // Word 1 (address 0x4) is written to zero so the last vector reads known data.
    single_op(OP_SW, 32'h4, 32'h0);

    // Vector table, applied back to back
    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = vecs[i].op; req_addr = vecs[i].addr;
      req_wdata = vecs[i].wdata; req_rt = vecs[i].rt; resp_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_req_ready", i), req_ready, 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_resp_valid", i), resp_valid, 1);
      check($sformatf("vec%0d_resp_data", i),  resp_data,  vecs[i].exp_data);
      check($sformatf("vec%0d_resp_err", i),   resp_err,   vecs[i].exp_err);
    end
    @(negedge clk) req_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_resp_valid", resp_valid, 0);

    // Back-pressure: 4 loads, resp_ready low for 3 cycles after first response
    bp_op[0] = OP_LW;  bp_addr[0] = 32'h0; bp_exp[0] = 32'hAABB_EEFF;
    bp_op[1] = OP_LW;  bp_addr[1] = 32'h8; bp_exp[1] = 32'h4455_6677;
    bp_op[2] = OP_LBU; bp_addr[2] = 32'h2; bp_exp[2] = 32'h0000_00EE;
    bp_op[3] = OP_LH;  bp_addr[3] = 32'h0; bp_exp[3] = 32'hFFFF_AABB;
    begin
      int sent = 0;
      int got = 0;
      int stall = 0;
      bit seen = 1'b0;
      logic [31:0] held = '0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        @(negedge clk);
        if (resp_valid && !seen) begin
          seen = 1'b1; stall = 3; held = resp_data;
        end
        resp_ready = (stall == 0);
        if (sent < 4) begin
          req_valid = 1'b1; req_op = bp_op[sent]; req_addr = bp_addr[sent];
        end else begin
          req_valid = 1'b0;
        end
        #1;
        if (stall > 0) begin
          check($sformatf("bp_stall%0d_req_ready", stall), req_ready, 0);
          check($sformatf("bp_stall%0d_hold", stall), resp_data, held);
          stall--;
        end
        if (resp_valid && resp_ready) begin
          check($sformatf("bp_resp%0d_data", got), resp_data, bp_exp[got]);
          check($sformatf("bp_resp%0d_err", got), resp_err, 0);
          got++;
        end
        if (req_valid && req_ready) sent++;
      end
      check("bp_resp_count", got, 4);
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_no_duplicate", resp_valid, 0);
    end

    // Reset while a load response is pending; a store done before reset persists
    resp_ready = 1'b1;
    single_op(OP_SW, 32'h10, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    check("pre_rst_resp_valid", resp_valid, 1);
    check("pre_rst_resp_data",  resp_data,  32'hCAFE_F00D);
    #2 rst = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data",  resp_data,  0);
    check("rst_resp_err",   resp_err,   0);
    @(negedge clk) rst = 1'b1;
    single_op(OP_LW, 32'h10, 32'h0);
    check("post_rst_lw_valid", resp_valid, 1);
    check("post_rst_lw_data",  resp_data,  32'hCAFE_F00D);
    single_op(OP_LW, 32'h8, 32'h0);
    check("post_rst_lw8_data", resp_data,  32'h4455_6677);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
